nascom_uart_tx: RTL and testbench

Serial transmitter section of the NASCOM serial/cassette path: a double-buffered, 6402-style UART transmitter that frames a parallel character into start / data / optional parity / stop bits on a single serial line. It pairs with the existing receive-side logic and feeds the cassette modulator and RS-232 driver. It runs from the system clock, advancing on a 16x baud-rate enable strobe.

---
 rtl/nascom_uart_pkg.sv | 27 ++
 rtl/nascom_uart_bitclk.sv | 36 +++
 rtl/nascom_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_nascom_uart_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nascom_uart_pkg.sv
// Shared definitions for the NASCOM UART transmit/receive path:
// frame states, word-length encodings and the cls decode helper.
package nascom_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam logic [1:0] CLS_5 = 2'b00;
   localparam logic [1:0] CLS_6 = 2'b01;
   localparam logic [1:0] CLS_7 = 2'b10;
   localparam logic [1:0] CLS_8 = 2'b11;

   function automatic logic [3:0] word_len(input logic [1:0] cls);
      case (cls)
         CLS_5:   word_len = 4'd5;
         CLS_6:   word_len = 4'd6;
         CLS_7:   word_len = 4'd7;
         default: word_len = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/nascom_uart_bitclk.sv
// Bit-period divider: counts OVERSAMPLE baud_en strobes per serial bit
// and pulses bit_done on the clock carrying the last strobe of a bit.
module nascom_uart_bitclk #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic baud_en,
   output logic bit_done
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      bit_done = baud_en && (cnt_q == LAST);
      cnt_d    = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (baud_en) begin
         cnt_d = bit_done ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nascom_uart_tx.sv
// Double-buffered 6402-style UART transmitter.
// Parity support is built only when NASCOM_UART_TX_PARITY_EN is defined.
module nascom_uart_tx
   import nascom_uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baud_en,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   input  logic [1:0] cls,
   input  logic       pe,
   input  logic       epe,
   input  logic       sbs,
   output logic       tbre,
   output logic       tre,
   output logic       tro
);

   tx_state_e  state_q, state_d;
   logic [7:0] buf_q, buf_d;
   logic       full_q, full_d;
   logic [7:0] shift_q, shift_d;
   logic [3:0] len_q, len_d;
   logic       par_en_q, par_en_d;
   logic       par_bit_q, par_bit_d;
   logic       sbs_q, sbs_d;
   logic [2:0] cnt_q, cnt_d;
   logic       tro_q, tro_d;

   logic       bit_done;
   logic       clr;
   logic       xfer;
   logic [3:0] len_new;

`ifdef NASCOM_UART_TX_PARITY_EN
   logic [7:0] masked;
`else
   logic       unused_cfg;
   assign unused_cfg = ^{pe, epe};
`endif

   // Start bit timing is anchored to the transfer, not the baud phase.
   assign clr = (state_q == IDLE) && full_q;

   nascom_uart_bitclk #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_bitclk (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .baud_en (baud_en),
      .bit_done(bit_done)
   );

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      full_d    = full_q;
      shift_d   = shift_q;
      len_d     = len_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      sbs_d     = sbs_q;
      cnt_d     = cnt_q;
      xfer      = 1'b0;
      len_new   = word_len(cls);

      case (state_q)
         IDLE: begin
            if (full_q) xfer = 1'b1;
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end
         DATA: begin
            if (bit_done) begin
               if ({1'b0, cnt_q} == len_q - 4'd1) begin
                  state_d = par_en_q ? PARITY : STOP;
                  cnt_d   = '0;
               end else begin
                  shift_d = shift_q >> 1;
                  cnt_d   = cnt_q + 3'd1;
               end
            end
         end
`ifdef NASCOM_UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done) state_d = STOP;
         end
`endif
         STOP: begin
            if (bit_done) begin
               if (sbs_q && cnt_q == 3'd0) begin
                  cnt_d = 3'd1;
               end else if (full_q) begin
                  xfer = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (xfer) begin
         state_d = START;
         full_d  = 1'b0;
         shift_d = buf_q;
         len_d   = len_new;
         sbs_d   = sbs;
         cnt_d   = '0;
`ifdef NASCOM_UART_TX_PARITY_EN
         masked    = buf_q & (8'hFF >> (4'd8 - len_new));
         par_en_d  = pe;
         par_bit_d = epe ? ^masked : ~^masked;
`else
         par_en_d  = 1'b0;
         par_bit_d = 1'b0;
`endif
      end

      if (tx_load && !full_q) begin
         buf_d  = tx_data;
         full_d = 1'b1;
      end

      case (state_d)
         START:   tro_d = 1'b0;
         DATA:    tro_d = shift_d[0];
         PARITY:  tro_d = par_bit_d;
         default: tro_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         buf_q     <= '0;
         full_q    <= 1'b0;
         shift_q   <= '0;
         len_q     <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         sbs_q     <= 1'b0;
         cnt_q     <= '0;
         tro_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         full_q    <= full_d;
         shift_q   <= shift_d;
         len_q     <= len_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         sbs_q     <= sbs_d;
         cnt_q     <= cnt_d;
         tro_q     <= tro_d;
      end
   end

   assign tbre = !full_q;
   assign tre  = (state_q == IDLE) && !full_q;
   assign tro  = tro_q;

endmodule

// File: tb/tb_nascom_uart_tx.sv
// Bench for nascom_uart_tx: frames built from bit-level rules, checked per clock.
module tb_nascom_uart_tx;

   localparam int OS = 16;

`ifdef NASCOM_UART_TX_PARITY_EN
   localparam bit PAR_OK = 1'b1;
`else
   localparam bit PAR_OK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, baud_en, tx_load, pe, epe, sbs;
   logic [7:0] tx_data;
   logic [1:0] cls;
   logic       tbre, tre, tro;

   int         checks, failures;
   int         cyc_n, load_at, baud_div, baud_cnt;
   logic [7:0] load_val;
   bit         exp_q[$];

   nascom_uart_tx #(.OVERSAMPLE(OS)) dut (
      .clk    (clk),
      .reset  (reset),
      .baud_en(baud_en),
      .tx_data(tx_data),
      .tx_load(tx_load),
      .cls    (cls),
      .pe     (pe),
      .epe    (epe),
      .sbs    (sbs),
      .tbre   (tbre),
      .tre    (tre),
      .tro    (tro)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
      tx_load = (cyc_n == load_at);
      if (tx_load) tx_data = load_val;
      baud_cnt++;
      baud_en = (baud_cnt % baud_div) == 0;
   endtask

   task automatic add_frame(input logic [7:0] d, input logic [1:0] c,
                            input bit p, input bit e, input bit s);
      int n;
      int ones;
      n = 5 + int'(c);
      ones = 0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (p && PAR_OK)
         exp_q.push_back(e ? bit'(ones % 2) : bit'((ones + 1) % 2));
      exp_q.push_back(1'b1);
      if (s) exp_q.push_back(1'b1);
   endtask

   task automatic start_frame(input logic [7:0] d);
      tx_data = d;
      tx_load = 1'b1;
      cyc();
      chk("load_tbre", tbre, 0);
      cyc();
      chk("xfer_tbre", tbre, 1);
      chk("xfer_tro", tro, 0);
      chk("xfer_tre", tre, 0);
   endtask

   task automatic run_bits(input int nbits, input bit tbre_exp);
      int idx;
      bit b;
      int strobes;
      int clocks;
      idx = 0;
      for (int k = 0; k < nbits; k++) begin
         b = exp_q.pop_front();
         strobes = 0;
         clocks = 0;
         while (strobes < OS && clocks < OS * 8) begin
            chk("tro", tro, b);
            chk("tre_busy", tre, 0);
            if (idx > 0) chk("tbre", tbre, tbre_exp);
            if (baud_en) strobes++;
            clocks++;
            idx++;
            cyc();
         end
         chk("bit_strobes", strobes, OS);
         if (k > 0) chk("bit_clocks", clocks, OS * baud_div);
      end
   endtask

   initial begin
      int c0;
      int na;
      logic [7:0] d;
      logic [1:0] c;
      bit p, e, s;

      checks = 0;
      failures = 0;
      cyc_n = 0;
      load_at = -1;
      load_val = 8'h00;
      baud_div = 1;
      baud_cnt = 0;
      baud_en = 1'b1;
      reset = 1'b1;
      tx_load = 1'b0;
      tx_data = 8'h00;
      cls = 2'b11;
      pe = 1'b0;
      epe = 1'b0;
      sbs = 1'b0;

      cyc();
      cyc();
      chk("rst_tro", tro, 1);
      chk("rst_tbre", tbre, 1);
      chk("rst_tre", tre, 1);
      reset = 1'b0;
      cyc();

      // 8N1 0x55, one strobe per clock
      add_frame(8'h55, 2'b11, 0, 0, 0);
      start_frame(8'h55);
      c0 = cyc_n;
      run_bits(exp_q.size(), 1);
      chk("len_8n1", cyc_n - c0, 10 * OS);
      chk("end_tre", tre, 1);
      chk("end_tro", tro, 1);
      repeat (3) cyc();

      // 7E2 0x83
      cls = 2'b10; pe = 1; epe = 1; sbs = 1;
      add_frame(8'h83, 2'b10, 1, 1, 1);
      start_frame(8'h83);
      run_bits(exp_q.size(), 1);
      chk("end_tre_7e2", tre, 1);
      repeat (2) cyc();

      // 5O1 0x1F
      cls = 2'b00; pe = 1; epe = 0; sbs = 0;
      add_frame(8'h1F, 2'b00, 1, 0, 0);
      start_frame(8'h1F);
      c0 = cyc_n;
      run_bits(exp_q.size(), 1);
      chk("len_5o1", cyc_n - c0, (PAR_OK ? 8 : 7) * OS);
      repeat (2) cyc();

      // baud_en every 4th clock
      baud_div = 4;
      cls = 2'b11; pe = 0; sbs = 0;
      d = 8'($urandom);
      add_frame(d, 2'b11, 0, 0, 0);
      start_frame(d);
      run_bits(exp_q.size(), 1);
      chk("end_tre_div4", tre, 1);
      baud_div = 1;
      repeat (2) cyc();

      // back-to-back, with an ignored load while the buffer is full
      add_frame(8'hA5, 2'b11, 0, 0, 0);
      na = exp_q.size();
      add_frame(8'h3C, 2'b11, 0, 0, 0);
      start_frame(8'hA5);
      tx_data = 8'h3C;
      tx_load = 1'b1;
      load_val = 8'hFF;
      load_at = cyc_n + 40;
      run_bits(na, 0);
      chk("b2b_tbre", tbre, 1);
      load_at = -1;
      run_bits(exp_q.size(), 1);
      chk("b2b_tre", tre, 1);
      for (int i = 0; i < 40; i++) begin
         chk("b2b_idle_tro", tro, 1);
         chk("b2b_idle_tre", tre, 1);
         cyc();
      end

      // random frames; config pins scrambled while each is in flight
      for (int r = 0; r < 8; r++) begin
         d = 8'($urandom);
         c = 2'($urandom_range(0, 3));
         p = 1'($urandom);
         e = 1'($urandom);
         s = 1'($urandom);
         baud_div = $urandom_range(1, 3);
         cls = c; pe = p; epe = e; sbs = s;
         add_frame(d, c, p, e, s);
         start_frame(d);
         cls = 2'($urandom); pe = 1'($urandom);
         epe = 1'($urandom); sbs = 1'($urandom);
         run_bits(exp_q.size(), 1);
         chk("rnd_tre", tre, 1);
         repeat ($urandom_range(0, 5)) cyc();
      end
      baud_div = 1;

      // reset in the middle of DATA with a byte waiting in the buffer
      cls = 2'b11; pe = 0; sbs = 0;
      start_frame(8'hF0);
      tx_data = 8'h0F;
      tx_load = 1'b1;
      cyc();
      chk("mid_tbre", tbre, 0);
      repeat (40) cyc();
      chk("mid_tro", tro, 0);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("mrst_tro", tro, 1);
      chk("mrst_tbre", tbre, 1);
      chk("mrst_tre", tre, 1);
      for (int i = 0; i < 60; i++) begin
         cyc();
         chk("mrst_idle_tro", tro, 1);
         chk("mrst_idle_tre", tre, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
